muldiv_seq: RTL and testbench

- Iterative multiply/divide sequencer attached to the execute stage of the combined ARM/RISC-V pipeline.
- Accepts one M-extension-class operation from E, runs a radix-2 shift-add multiply or a restoring divide over WIDTH cycles, and stalls F/D/E until the result is ready.
- Presents a one-cycle result strobe that the E-stage result mux selects instead of the ALU output.
- Honours FlushE so that a squashed instruction never produces a result.

---
 rtl/muldiv_pkg.sv | 49 ++++
 rtl/muldiv_iter.sv | 41 ++++
 rtl/muldiv_seq.sv | 171 +++++++++++++++++
 tb/tb_muldiv_seq.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types and decode predicates for the iterative
// multiply/divide sequencer.
//   muldiv_op_t : M-extension operation encoding as presented on OpE.
//   md_state_t  : sequencer FSM states.
//   is_div / is_signed_a / is_signed_b / returns_high / returns_rem :
//                 per-operation decode used at start and at completion.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } muldiv_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } md_state_t;

  function automatic logic is_div(input muldiv_op_t op);
    return (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
  endfunction

  // MUL only returns the low word, which is identical for signed and
  // unsigned operands, so it is treated as unsigned.
  function automatic logic is_signed_a(input muldiv_op_t op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic is_signed_b(input muldiv_op_t op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic returns_high(input muldiv_op_t op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_MULHU);
  endfunction

  function automatic logic returns_rem(input muldiv_op_t op);
    return (op == OP_REM) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// muldiv_iter: one combinational iteration of the sequencer datapath.
//   div_mode : 1 = restoring divide step, 0 = shift-add multiply step
//   acc      : 2*WIDTH working register
//                multiply: {partial high, remaining multiplier / product low}
//                divide  : {partial remainder, remaining dividend / quotient}
//   opb      : multiplicand (multiply) or divisor (divide) magnitude
//   acc_next : working register after this step
module muldiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic                 div_mode,
  input  logic [2*WIDTH-1:0]   acc,
  input  logic [WIDTH-1:0]     opb,
  output logic [2*WIDTH-1:0]   acc_next
);

  logic [WIDTH:0] mul_sum;
  logic [WIDTH:0] div_shift;
  logic [WIDTH:0] div_diff;
  logic           div_ge;

  always_comb begin
    // Multiply: add multiplicand into the high half when the current
    // multiplier bit is set; the carry is kept and shifted back in.
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : {(WIDTH+1){1'b0}});
    // Divide: shift the next dividend bit into the partial remainder.
    // The remainder stays below the divisor, so WIDTH+1 bits never overflow.
    div_shift = acc[2*WIDTH-1:WIDTH-1];
    div_ge    = (div_shift >= {1'b0, opb});
    div_diff  = div_shift - {1'b0, opb};
    acc_next  = {mul_sum, acc[WIDTH-1:1]};
    if (div_mode) begin
      if (div_ge) begin
        acc_next = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      end else begin
        acc_next = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative multiply/divide sequencer for the execute stage.
// Runs a radix-2 shift-add multiply or restoring divide over WIDTH cycles
// on operand magnitudes and applies the sign fix-up at completion.
//   clk, rst   : clock; synchronous active-low reset
//   StartE     : mul/div instruction valid in E
//   OpE        : operation (muldiv_op_t encoding)
//   SrcAE/BE   : forwarded operands (A dividend/multiplicand, B divisor/multiplier)
//   FlushE     : squash the instruction in E (wins over start and completion)
//   StallMD    : hold F/D/E while an operation is accepted or running
//   DoneE      : one-cycle result strobe
//   MDResultE  : result, held until the next completion
//   BusyE      : sequencer not idle
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             StartE,
  input  logic [2:0]       OpE,
  input  logic [WIDTH-1:0] SrcAE,
  input  logic [WIDTH-1:0] SrcBE,
  input  logic             FlushE,
  output logic             StallMD,
  output logic             DoneE,
  output logic [WIDTH-1:0] MDResultE,
  output logic             BusyE
);

  md_state_t            state_reg;
  logic [CNT_W-1:0]     count_reg;
  logic [2*WIDTH-1:0]   acc_reg;
  logic [WIDTH-1:0]     opb_reg;
  muldiv_op_t           op_reg;
  logic                 neg_res_reg;
  logic                 neg_rem_reg;
  logic [WIDTH-1:0]     result_reg;
  logic                 done_reg;
  logic                 busy_reg;

  muldiv_op_t           op_in;
  logic                 sign_a;
  logic                 sign_b;
  logic [WIDTH-1:0]     mag_a;
  logic [WIDTH-1:0]     mag_b;
  logic                 start_ok;
  logic                 div_zero;
  logic                 div_ovf;
  logic [WIDTH-1:0]     quick_result;
  logic [2*WIDTH-1:0]   acc_next;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     quo_fix;
  logic [WIDTH-1:0]     rem_fix;
  logic [WIDTH-1:0]     final_result;

  // Start-side decode on the live E-stage inputs.
  always_comb begin
    op_in    = muldiv_op_t'(OpE);
    sign_a   = is_signed_a(op_in) & SrcAE[WIDTH-1];
    sign_b   = is_signed_b(op_in) & SrcBE[WIDTH-1];
    mag_a    = sign_a ? (-SrcAE) : SrcAE;
    mag_b    = sign_b ? (-SrcBE) : SrcBE;
    start_ok = (state_reg == ST_IDLE) & StartE & ~FlushE;
    div_zero = (SrcBE == '0);
    div_ovf  = is_signed_b(op_in) & (SrcAE == {1'b1, {(WIDTH-1){1'b0}}}) & (SrcBE == '1);
    // Special divides finish without iterating.
    quick_result = '0;
    if (div_zero) begin
      quick_result = returns_rem(op_in) ? SrcAE : '1;
    end else if (div_ovf) begin
      quick_result = returns_rem(op_in) ? '0 : SrcAE;
    end
  end

  muldiv_iter #(
    .WIDTH(WIDTH)
  ) u_iter (
    .div_mode (state_reg == ST_DIV),
    .acc      (acc_reg),
    .opb      (opb_reg),
    .acc_next (acc_next)
  );

  // Sign fix-up applied to the output of the last iteration.
  always_comb begin
    prod_fix = neg_res_reg ? (-acc_next) : acc_next;
    quo_fix  = neg_res_reg ? (-acc_next[WIDTH-1:0]) : acc_next[WIDTH-1:0];
    rem_fix  = neg_rem_reg ? (-acc_next[2*WIDTH-1:WIDTH]) : acc_next[2*WIDTH-1:WIDTH];
    if (is_div(op_reg)) begin
      final_result = returns_rem(op_reg) ? rem_fix : quo_fix;
    end else begin
      final_result = returns_high(op_reg) ? prod_fix[2*WIDTH-1:WIDTH] : prod_fix[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg   <= ST_IDLE;
      count_reg   <= '0;
      acc_reg     <= '0;
      opb_reg     <= '0;
      op_reg      <= OP_MUL;
      neg_res_reg <= 1'b0;
      neg_rem_reg <= 1'b0;
      result_reg  <= '0;
      done_reg    <= 1'b0;
      busy_reg    <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          done_reg <= 1'b0;
          if (start_ok) begin
            op_reg      <= op_in;
            neg_res_reg <= sign_a ^ sign_b;
            neg_rem_reg <= sign_a;
            count_reg   <= CNT_W'(WIDTH - 1);
            busy_reg    <= 1'b1;
            if (is_div(op_in) && (div_zero || div_ovf)) begin
              result_reg <= quick_result;
              done_reg   <= 1'b1;
              state_reg  <= ST_DONE;
            end else if (is_div(op_in)) begin
              acc_reg   <= {{WIDTH{1'b0}}, mag_a};
              opb_reg   <= mag_b;
              state_reg <= ST_DIV;
            end else begin
              acc_reg   <= {{WIDTH{1'b0}}, mag_b};
              opb_reg   <= mag_a;
              state_reg <= ST_MUL;
            end
          end
        end
        ST_MUL, ST_DIV: begin
          if (FlushE) begin
            state_reg <= ST_IDLE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
          end else begin
            acc_reg <= acc_next;
            if (count_reg == '0) begin
              result_reg <= final_result;
              done_reg   <= 1'b1;
              state_reg  <= ST_DONE;
            end else begin
              count_reg <= count_reg - 1'b1;
            end
          end
        end
        ST_DONE: begin
          // The instruction is leaving E; StartE here is the same one.
          state_reg <= ST_IDLE;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
        end
        default: begin
          state_reg <= ST_IDLE;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign StallMD   = start_ok | (state_reg == ST_MUL) | (state_reg == ST_DIV);
  assign DoneE     = done_reg;
  assign MDResultE = result_reg;
  assign BusyE     = busy_reg;

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: directed, table-driven bench for muldiv_seq plus
// hand-written sequences for flush, back-to-back and mid-run reset.
module tb_muldiv_seq;

  localparam int WIDTH = 32;
  localparam int LONG  = WIDTH + 1;
  localparam int NVEC  = 19;

  logic             clk;
  logic             rst;
  logic             StartE;
  logic [2:0]       OpE;
  logic [WIDTH-1:0] SrcAE;
  logic [WIDTH-1:0] SrcBE;
  logic             FlushE;
  logic             StallMD;
  logic             DoneE;
  logic [WIDTH-1:0] MDResultE;
  logic             BusyE;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    int          lat;
  } vec_t;

  vec_t vecs [NVEC];

  muldiv_seq #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .StartE    (StartE),
    .OpE       (OpE),
    .SrcAE     (SrcAE),
    .SrcBE     (SrcBE),
    .FlushE    (FlushE),
    .StallMD   (StallMD),
    .DoneE     (DoneE),
    .MDResultE (MDResultE),
    .BusyE     (BusyE)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issue one instruction, holding StartE through the stall and the DONE
  // cycle, then drop it once the sequencer is back in IDLE.
  task automatic run_op(input int idx, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
    int lat;
    int stalls;
    @(negedge clk);
    StartE = 1'b1; OpE = op; SrcAE = a; SrcBE = b;
    #1;
    lat = -1;
    stalls = StallMD ? 1 : 0;
    for (int k = 1; k <= 60 && lat < 0; k++) begin
      @(negedge clk); #1;
      if (StallMD) stalls++;
      if (DoneE) lat = k;
    end
    check($sformatf("vec%0d_latency", idx), 64'(lat), 64'(exp_lat));
    check($sformatf("vec%0d_result", idx), 64'(MDResultE), 64'(exp_res));
    check($sformatf("vec%0d_stall_cycles", idx), 64'(stalls), 64'(exp_lat));
    check($sformatf("vec%0d_stall_in_done", idx), 64'(StallMD), 64'd0);
    @(negedge clk);
    StartE = 1'b0;
    #1;
    check($sformatf("vec%0d_busy_after", idx), 64'(BusyE), 64'd0);
    check($sformatf("vec%0d_done_after", idx), 64'(DoneE), 64'd0);
    check($sformatf("vec%0d_result_held", idx), 64'(MDResultE), 64'(exp_res));
    $display("vec %0d: op=%0d a=%h b=%h -> result=%h latency=%0d", idx, op, a, b, MDResultE, lat);
  endtask

  initial begin
    int dones;
    int lat;
    logic [31:0] prev;

    vecs[0]  = '{3'd0, 32'd7,         32'd6,         32'd42,        LONG};
    vecs[1]  = '{3'd1, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'h00000000,  LONG};
    vecs[2]  = '{3'd3, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'hFFFFFFFE,  LONG};
    vecs[3]  = '{3'd4, 32'hFFFFFFF9,  32'd2,         32'hFFFFFFFD,  LONG};
    vecs[4]  = '{3'd6, 32'hFFFFFFF9,  32'd2,         32'hFFFFFFFF,  LONG};
    vecs[5]  = '{3'd5, 32'd100,       32'd7,         32'd14,        LONG};
    vecs[6]  = '{3'd7, 32'd100,       32'd7,         32'd2,         LONG};
    vecs[7]  = '{3'd4, 32'd5,         32'd0,         32'hFFFFFFFF,  1};
    vecs[8]  = '{3'd6, 32'd5,         32'd0,         32'd5,         1};
    vecs[9]  = '{3'd5, 32'd5,         32'd0,         32'hFFFFFFFF,  1};
    vecs[10] = '{3'd7, 32'd5,         32'd0,         32'd5,         1};
    vecs[11] = '{3'd4, 32'h80000000,  32'hFFFFFFFF,  32'h80000000,  1};
    vecs[12] = '{3'd6, 32'h80000000,  32'hFFFFFFFF,  32'h00000000,  1};
    vecs[13] = '{3'd5, 32'h80000000,  32'hFFFFFFFF,  32'h00000000,  LONG};
    vecs[14] = '{3'd2, 32'hFFFFFFFF,  32'd2,         32'hFFFFFFFF,  LONG};
    vecs[15] = '{3'd0, 32'h12345678,  32'h10,        32'h23456780,  LONG};
    vecs[16] = '{3'd1, 32'h80000000,  32'h80000000,  32'h40000000,  LONG};
    vecs[17] = '{3'd4, 32'hFFFFFFF8,  32'hFFFFFFFD,  32'd2,         LONG};
    vecs[18] = '{3'd6, 32'hFFFFFFF8,  32'hFFFFFFFD,  32'hFFFFFFFE,  LONG};

    rst = 1'b0; StartE = 1'b0; OpE = 3'd0; SrcAE = '0; SrcBE = '0; FlushE = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_result", 64'(MDResultE), 64'd0);
    check("reset_done",   64'(DoneE),     64'd0);
    check("reset_busy",   64'(BusyE),     64'd0);
    check("reset_stall",  64'(StallMD),   64'd0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      run_op(i, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].lat);
    end
    prev = vecs[NVEC-1].res;

    // Flush mid-run: squashed MUL never completes, result register untouched.
    @(negedge clk);
    StartE = 1'b1; OpE = 3'd0; SrcAE = 32'd3; SrcBE = 32'd3;
    repeat (10) @(negedge clk);
    FlushE = 1'b1;
    @(negedge clk);
    FlushE = 1'b0; StartE = 1'b0;
    #1;
    check("flush_stall", 64'(StallMD), 64'd0);
    check("flush_busy",  64'(BusyE),   64'd0);
    dones = 0;
    for (int k = 0; k < 40; k++) begin
      if (DoneE) dones++;
      @(negedge clk); #1;
    end
    check("flush_no_done", 64'(dones), 64'd0);
    check("flush_result_kept", 64'(MDResultE), 64'(prev));
    $display("flush: MUL squashed at N+10, result=%h", MDResultE);

    // Back-to-back: StartE stays high through DONE; next op follows at once.
    @(negedge clk);
    StartE = 1'b1; OpE = 3'd0; SrcAE = 32'd7; SrcBE = 32'd6;
    dones = 0; lat = -1;
    for (int k = 1; k <= LONG; k++) begin
      @(negedge clk); #1;
      if (DoneE) begin dones++; lat = k; end
    end
    check("b2b_first_done_count", 64'(dones), 64'd1);
    check("b2b_first_latency", 64'(lat), 64'(LONG));
    check("b2b_first_result", 64'(MDResultE), 64'd42);
    @(negedge clk);
    OpE = 3'd5; SrcAE = 32'd100; SrcBE = 32'd7;
    #1;
    check("b2b_no_restart_in_done", 64'(BusyE), 64'd0);
    check("b2b_second_accept", 64'(StallMD), 64'd1);
    dones = 0; lat = -1;
    for (int k = 1; k <= LONG; k++) begin
      @(negedge clk); #1;
      if (DoneE) begin dones++; lat = k; end
    end
    check("b2b_second_done_count", 64'(dones), 64'd1);
    check("b2b_second_latency", 64'(lat), 64'(LONG));
    check("b2b_second_result", 64'(MDResultE), 64'd14);
    @(negedge clk);
    StartE = 1'b0;
    $display("back-to-back: MUL then DIVU, result=%h", MDResultE);

    // Reset in the middle of a divide.
    @(negedge clk);
    StartE = 1'b1; OpE = 3'd4; SrcAE = 32'd100; SrcBE = 32'd7;
    repeat (6) @(negedge clk);
    rst = 1'b0; StartE = 1'b0;
    @(negedge clk); #1;
    check("midrst_result", 64'(MDResultE), 64'd0);
    check("midrst_done",   64'(DoneE),     64'd0);
    check("midrst_busy",   64'(BusyE),     64'd0);
    check("midrst_stall",  64'(StallMD),   64'd0);
    rst = 1'b1;
    dones = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk); #1;
      if (DoneE) dones++;
    end
    check("midrst_no_done", 64'(dones), 64'd0);
    $display("mid-run reset: outputs cleared, result=%h", MDResultE);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
